// File: rtl/serial_collector_pkg.sv
// Shared definitions for the serial word collector:
//   WIDTH_DEFAULT - default assembled word width (30 bits)
//   state_e       - collector FSM states (IDLE, COLLECT, PARITY)
//   cnt_width()   - bit counter width able to hold 0..w
package serial_collector_pkg;

  localparam int unsigned WIDTH_DEFAULT = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/collector_hold_reg.sv
// One-entry valid/ready hold register for completed words.
//   clk_i       - clock
//   rst_ni      - asynchronous active-low reset
//   in_valid_i  - load in_data_i this cycle (caller guarantees room)
//   in_data_i   - word to load
//   out_ready_i - consumer takes the held word
//   out_valid_o - a word is held
//   out_data_o  - held word; stable until consumed
// A load on the same cycle as a consume replaces the word with no bubble.
module collector_hold_reg #(
  parameter int unsigned WIDTH = 30
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
    if (in_valid_i) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector, LSB-first, with a one-entry output
// hold register and valid/ready handshakes on both sides.
//   clk        - clock
//   reset      - asynchronous active-low reset
//   ser_in     - serial data bit
//   ser_valid  - ser_in valid this cycle
//   ser_ready  - collector accepts a bit this cycle
//   flush      - synchronous discard of the partial word (wins over a bit)
//   word_out   - assembled word
//   word_valid - word_out holds a complete word
//   word_ready - consumer takes the word
//   parity_err - one-cycle pulse on an even-parity mismatch
// Build option: define SERIAL_COLLECTOR_PARITY_CHECK_EN to expect one
// even-parity bit after every word; otherwise parity_err is tied 0.
module serial_word_collector
  import serial_collector_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             parity_err
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // With parity the whole word must sit in the shifter while the parity
  // bit is awaited; without it the last data bit goes straight to the hold
  // register, so only WIDTH-1 bits need storing.
`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
  localparam int unsigned PW = WIDTH;
`else
  localparam int unsigned PW = WIDTH - 1;
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     part_q, part_d;
  logic              accept;
  logic              completing;
  logic              load;
  logic [WIDTH-1:0]  load_word;

`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
  logic perr_q, perr_d;
  assign completing = (state_q == PARITY);
  assign load_word  = part_q;
`else
  assign completing = (cnt_q == LAST_CNT);
  assign load_word  = {ser_in, part_q};
`endif

  // Stall only when the next bit would finish a word that has nowhere to go.
  assign ser_ready = !(word_valid && !word_ready && completing);
  assign accept    = ser_valid && ser_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    load    = 1'b0;
`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
    perr_d  = 1'b0;
`endif
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      part_d  = '0;
    end else if (accept) begin
      case (state_q)
        IDLE, COLLECT: begin
          // Right shift: the first bit ends up in the lowest position.
          part_d         = part_q >> 1;
          part_d[PW-1]   = ser_in;
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            part_d  = '0;
            load    = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = COLLECT;
          end
        end
`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
        PARITY: begin
          state_d = IDLE;
          part_d  = '0;
          if (ser_in == ^part_q) begin
            load = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          part_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
    end
  end

`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  collector_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk_i      (clk),
    .rst_ni     (reset),
    .in_valid_i (load),
    .in_data_i  (load_word),
    .out_ready_i(word_ready),
    .out_valid_o(word_valid),
    .out_data_o (word_out)
  );

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed self-checking bench for serial_word_collector (WIDTH = 30).
module tb_serial_word_collector;

  localparam int unsigned W = 30;
`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
  localparam int unsigned BPW = W + 1;
`else
  localparam int unsigned BPW = W;
`endif

  logic         clk        = 1'b0;
  logic         reset      = 1'b0;
  logic         ser_in     = 1'b0;
  logic         ser_valid  = 1'b0;
  logic         flush      = 1'b0;
  logic         word_ready = 1'b0;
  logic         ser_ready;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         parity_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  serial_word_collector #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .flush     (flush),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Data bits followed (in the parity build) by the even-parity bit.
  function automatic logic [63:0] stream_of(input logic [W-1:0] w);
    logic [63:0] s;
    s = 64'(w);
`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
    s[W] = ^w;
`endif
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [63:0] s, input int unsigned n,
                           input bit chk_ready, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      ser_in    = s[i];
      ser_valid = 1'b1;
      #1;
      if (chk_ready) check({tag, "_ser_ready"}, 64'(ser_ready), 64'd1);
      tick();
    end
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  // Sends a full word into an empty hold register and checks the
  // one-cycle latency and the delivered value.
  task automatic deliver(input string tag, input logic [W-1:0] w,
                         input logic [W-1:0] exp, input bit chk_ready);
    logic [63:0] s;
    s = stream_of(w);
    send_bits(s, BPW - 1, chk_ready, tag);
    ser_in    = s[BPW-1];
    ser_valid = 1'b1;
    #1;
    check({tag, "_not_early"}, 64'(word_valid), 64'd0);
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    check({tag, "_valid"}, 64'(word_valid), 64'd1);
    check({tag, "_word"}, 64'(word_out), 64'(exp));
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_word;
  } vec_t;

  vec_t         vecs[6];
  logic [W-1:0] cw[3];
  logic [63:0]  s;
  logic [W-1:0] wa, wb;

  initial begin
    vecs[0] = '{30'h2AAAAAAA, 30'h2AAAAAAA};
    vecs[1] = '{30'h00000001, 30'h00000001};
    vecs[2] = '{30'h20000000, 30'h20000000};
    vecs[3] = '{30'h3FFFFFFF, 30'h3FFFFFFF};
    vecs[4] = '{30'h15555555, 30'h15555555};
    vecs[5] = '{30'h00000000, 30'h00000000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_word_valid", 64'(word_valid), 64'd0);
    check("rst_word_out", 64'(word_out), 64'd0);
    check("rst_parity_err", 64'(parity_err), 64'd0);
    reset = 1'b1;
    #1;
    check("rst_ser_ready", 64'(ser_ready), 64'd1);
    tick();

    // Table: single words, consumer always ready
    word_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      deliver($sformatf("tbl%0d", v), vecs[v].data, vecs[v].exp_word, 1'b1);
      tick();
      check($sformatf("tbl%0d_consumed", v), 64'(word_valid), 64'd0);
    end

    // Backpressure: two words back-to-back, consumer stalled
    word_ready = 1'b0;
    wa = 30'h0F0F0F0F;
    wb = 30'h3C3C3C3C;
    send_bits(stream_of(wa), BPW, 1'b0, "bp");
    check("bp_first_valid", 64'(word_valid), 64'd1);
    check("bp_first_word", 64'(word_out), 64'(wa));
    s = stream_of(wb);
    send_bits(s, BPW - 1, 1'b1, "bp_second");
    ser_in    = s[BPW-1];
    ser_valid = 1'b1;
    #1;
    check("bp_stall_ready", 64'(ser_ready), 64'd0);
    tick();
    tick();
    check("bp_hold_valid", 64'(word_valid), 64'd1);
    check("bp_hold_word", 64'(word_out), 64'(wa));
    word_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(ser_ready), 64'd1);
    tick();
    ser_valid = 1'b0;
    check("bp_nobubble_valid", 64'(word_valid), 64'd1);
    check("bp_second_word", 64'(word_out), 64'(wb));
    tick();
    check("bp_drained", 64'(word_valid), 64'd0);

    // Flush after 12 bits, including flush colliding with a valid bit
    send_bits(64'hFFF, 12, 1'b0, "fl");
    flush     = 1'b1;
    ser_in    = 1'b1;
    ser_valid = 1'b1;
    tick();
    flush     = 1'b0;
    ser_valid = 1'b0;
    check("fl_no_word", 64'(word_valid), 64'd0);
    deliver("fl", 30'h0000001, 30'h0000001, 1'b1);
    tick();
    check("fl_consumed", 64'(word_valid), 64'd0);

    // Reset mid-hold and mid-word
    word_ready = 1'b0;
    send_bits(stream_of(30'h155), BPW, 1'b0, "rs");
    check("rs_held", 64'(word_valid), 64'd1);
    send_bits(64'hFFFFF, 20, 1'b0, "rs");
    reset = 1'b0;
    #1;
    check("rs_async_valid", 64'(word_valid), 64'd0);
    check("rs_async_word", 64'(word_out), 64'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rs_ready_after", 64'(ser_ready), 64'd1);
    word_ready = 1'b1;
    deliver("rs", 30'h3FFFFFFF, 30'h3FFFFFFF, 1'b1);
    tick();
    check("rs_single_word", 64'(word_valid), 64'd0);

    // Continuous stream, consumer always ready
    cw[0] = 30'h12345678;
    cw[1] = 30'h2DCBA987;
    cw[2] = 30'h00FF00FF;
    for (int w = 0; w < 3; w++) begin
      s = stream_of(cw[w]);
      for (int unsigned i = 0; i < BPW; i++) begin
        ser_in    = s[i];
        ser_valid = 1'b1;
        #1;
        check($sformatf("st%0d_ready", w), 64'(ser_ready), 64'd1);
        tick();
        check($sformatf("st%0d_valid_b%0d", w, i), 64'(word_valid),
              64'(i == BPW - 1));
        if (i == BPW - 1) check($sformatf("st%0d_word", w), 64'(word_out), 64'(cw[w]));
      end
    end
    ser_valid = 1'b0;
    tick();
    check("st_drained", 64'(word_valid), 64'd0);

`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
    // Wrong parity drops the word; correct parity delivers it
    s    = 64'h1;
    s[W] = 1'b0;
    send_bits(s, BPW, 1'b0, "par");
    check("par_err_pulse", 64'(parity_err), 64'd1);
    check("par_dropped", 64'(word_valid), 64'd0);
    tick();
    check("par_err_single", 64'(parity_err), 64'd0);
    check("par_still_dropped", 64'(word_valid), 64'd0);
    deliver("par_ok", 30'h1, 30'h1, 1'b0);
    check("par_ok_no_err", 64'(parity_err), 64'd0);
    tick();
`else
    check("parity_err_tied", 64'(parity_err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
SERIAL_WORD_COLLECTOR -- requirements
Module: serial_word_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 30, giving the assembled word width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port ser_in, input, 1 bit: serial data bit.
REQ-005 SHALL have port ser_valid, input, 1 bit: ser_in is valid this cycle.
REQ-006 SHALL have port ser_ready, output, 1 bit: the collector accepts a bit this cycle.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of the partial word.
REQ-008 SHALL have port word_out, output, WIDTH bits: assembled word; feeds the shift register's data_in.
REQ-009 SHALL have port word_valid, output, 1 bit: word_out holds a complete word.
REQ-010 SHALL have port word_ready, input, 1 bit: the consumer takes the word; word_valid&word_ready drives the shift register's load.
REQ-011 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch; tied 0 when the parity feature is compiled out.

Function
REQ-012 A bit SHALL be accepted only on a cycle with ser_valid=1 and ser_ready=1.
REQ-013 Assembly SHALL be LSB-first: the first accepted bit of a word lands in word_out[0] and the WIDTH-th lands in word_out[WIDTH-1], matching the right-shifting consumer.
REQ-014 The FSM SHALL have states IDLE (bit count 0), COLLECT (1..WIDTH-1 bits held) and PARITY (awaiting the parity bit; present only with the parity macro).
REQ-015 FSM transitions SHALL be: IDLE->COLLECT on the first accepted bit; COLLECT->IDLE on the WIDTH-th accepted bit (or COLLECT->PARITY with the macro); PARITY->IDLE on the accepted parity bit.
REQ-016 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL wrap to 0 on word completion, never exceeding WIDTH.
REQ-017 The completed word SHALL load into a one-entry hold register; word_valid SHALL rise on the cycle after the completing bit is accepted (latency 1).
REQ-018 word_valid and word_out SHALL stay stable until the cycle after word_valid&word_ready.
REQ-019 ser_ready SHALL be 0 only when the hold register is full, word_ready=0, and the next accepted bit would complete a word; ser_ready SHALL not depend combinationally on ser_valid.
REQ-020 If a word is consumed and a new word completes on the same cycle, the hold register SHALL take the new word and word_valid SHALL stay 1 with no bubble.
REQ-021 flush SHALL clear the partial word and counter and return the FSM to IDLE; it SHALL not affect the hold register.
REQ-022 If flush and an accepted bit occur on the same cycle, flush SHALL win and the bit SHALL be discarded.

Reset
REQ-023 While reset=0, the block SHALL clear FSM=IDLE, counter=0, partial word=0, word_out=0, word_valid=0, parity_err=0, with ser_ready=1 after release.
REQ-024 Reset asserted mid-word or mid-hold SHALL drop all data immediately; no word SHALL be emitted from pre-reset bits.

Configuration
REQ-025 The macro SERIAL_COLLECTOR_PARITY_CHECK_EN SHALL control the parity feature.
REQ-026 With the macro defined, each word SHALL be followed by one even-parity bit.
REQ-027 With the macro defined, a mismatch SHALL drop the word (word_valid stays 0) and pulse parity_err for one cycle, on the cycle after the parity bit is accepted.
REQ-028 Without the macro, there SHALL be no PARITY state and parity_err SHALL be constant 0.

Structure
REQ-029 The shared package serial_collector_pkg SHALL hold the WIDTH default constant (30), the FSM state enum (IDLE, COLLECT, PARITY) and the counter-width function.
REQ-030 The single sub-module collector_hold_reg SHALL implement the one-entry valid/ready hold register.

Verification
REQ-031 Bench SHALL cover: 30 bits of 30'h2AAAAAAA LSB-first with word_ready=1 -> word_out=30'h2AAAAAAA, word_valid=1 exactly 1 cycle after the 30th bit.
REQ-032 Bench SHALL cover: word_ready=0, two words sent back-to-back -> ser_ready=0 before the 60th bit; word_ready=1 -> first word, then second word, none lost.
REQ-033 Bench SHALL cover: flush after 12 bits, then 30 bits of 30'h0000001 -> word_out=30'h0000001; none of the first 12 bits appear.
REQ-034 Bench SHALL cover: reset=0 for one cycle at bit 20, then a full word 30'h3FFFFFFF -> only 30'h3FFFFFFF is emitted.
REQ-035 Bench SHALL cover (macro defined): word 30'h1 with parity bit 0 -> parity_err pulses once and word_valid stays 0; with parity bit 1 -> the word is delivered.
REQ-036 Bench SHALL cover: word_ready held 1 with continuous ser_valid -> a word every 30 cycles and ser_ready stays 1 throughout.
